// File: rtl/calculator_input_ctrl.sv
// calculator_input_ctrl
//   Front end for the calculator FSM. It synchronizes and debounces five push-buttons and
//   SW_BITS slide switches, detects presses, and issues one operation per press: a 1-cycle
//   start with a one-hot buttons code. While the calculator and divider finish, the operand
//   is held stable and new presses are locked out.
//
//   Button bit positions: 0=UP 1=DOWN 2=LEFT 3=RIGHT 4=CENTER. A lower index has higher
//   priority, which matches the calculator's decode order.
//
//   Optional feature: define PRESS_QUEUE_EN to enable a 1-entry pending-press slot. Without
//   it, every press that arrives while busy is dropped.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   btn_raw  in   [4:0] asynchronous buttons
//   sw_raw   in   [SW_BITS-1:0] asynchronous slide switches
//   start    out  1-cycle operation strobe
//   buttons  out  [4:0] one-hot op code, valid from start through the holdoff, else 0
//   switch   out  [SW_BITS-1:0] operand, frozen while busy, otherwise the live synced value
//   busy     out  high while issuing or holding off
//   overrun  out  1-cycle pulse when a press is discarded
module calculator_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned HOLDOFF      = 40,
  parameter int unsigned SW_BITS      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         btn_raw,
  input  logic [SW_BITS-1:0] sw_raw,
  output logic               start,
  output logic [4:0]         buttons,
  output logic [SW_BITS-1:0] switch,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned DbW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned HoldW = $clog2(HOLDOFF);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYC - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

  state_e               state_q, state_d;
  logic [4:0]           btn_s1_q, btn_s2_q;
  logic [SW_BITS-1:0]   sw_s1_q, sw_s2_q;
  logic [4:0]           deb_q, deb_d, deb_prev_q;
  logic [4:0][DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [4:0]           code_q, code_d;
  logic [SW_BITS-1:0]   sw_lat_q, sw_lat_d;
  logic                 overrun_q, overrun_d;
`ifdef PRESS_QUEUE_EN
  logic                 pend_v_q, pend_v_d;
  logic [4:0]           pend_code_q, pend_code_d;
`endif

  logic [4:0] press, win;
  logic       any_press, multi_press;

  // A press is the rising edge of a debounced level.
  assign press       = deb_q & ~deb_prev_q;
  // Isolate the lowest set bit, which is the highest-priority button.
  assign win         = press & (~press + 5'd1);
  assign any_press   = |press;
  assign multi_press = |(press & (press - 5'd1));

  // Debounce: the level flips after the synced value has differed for DEBOUNCE_CYC cycles.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (btn_s2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          deb_d[i]    = ~deb_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    code_d     = code_q;
    sw_lat_d   = sw_lat_q;
    overrun_d  = 1'b0;
`ifdef PRESS_QUEUE_EN
    pend_v_d    = pend_v_q;
    pend_code_d = pend_code_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_press) begin
          state_d   = StIssue;
          code_d    = win;
          sw_lat_d  = sw_s2_q;
          overrun_d = multi_press;
        end
      end
      StIssue, StHold: begin
        if (state_q == StHold && hold_cnt_q == HoldLast) begin
`ifdef PRESS_QUEUE_EN
          if (pend_v_q) begin
            state_d   = StIssue;
            code_d    = pend_code_q;
            sw_lat_d  = sw_s2_q;
            pend_v_d  = 1'b0;
            overrun_d = any_press;
          end else if (any_press) begin
            // Slot is empty, so the press is stored and consumed on the same edge.
            state_d   = StIssue;
            code_d    = win;
            sw_lat_d  = sw_s2_q;
            overrun_d = multi_press;
          end else begin
            state_d = StIdle;
          end
`else
          state_d   = StIdle;
          overrun_d = any_press;
`endif
        end else begin
          if (state_q == StIssue) begin
            state_d    = StHold;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
`ifdef PRESS_QUEUE_EN
          if (any_press) begin
            if (pend_v_q) begin
              overrun_d = 1'b1;
            end else begin
              pend_v_d    = 1'b1;
              pend_code_d = win;
              overrun_d   = multi_press;
            end
          end
`else
          overrun_d = any_press;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      code_q     <= '0;
      sw_lat_q   <= '0;
      overrun_q  <= 1'b0;
`ifdef PRESS_QUEUE_EN
      pend_v_q    <= 1'b0;
      pend_code_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      btn_s1_q   <= btn_raw;
      btn_s2_q   <= btn_s1_q;
      sw_s1_q    <= sw_raw;
      sw_s2_q    <= sw_s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      code_q     <= code_d;
      sw_lat_q   <= sw_lat_d;
      overrun_q  <= overrun_d;
`ifdef PRESS_QUEUE_EN
      pend_v_q    <= pend_v_d;
      pend_code_q <= pend_code_d;
`endif
    end
  end

  always_comb begin
    busy    = (state_q != StIdle);
    start   = (state_q == StIssue);
    buttons = busy ? code_q : 5'd0;
    switch  = busy ? sw_lat_q : sw_s2_q;
    overrun = overrun_q;
  end

endmodule

// File: tb/tb_calculator_input_ctrl.sv
module tb_calculator_input_ctrl;
  localparam int D = 4;
  localparam int H = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  btn_raw;
  logic [15:0] sw_raw;
  logic        start, busy, overrun;
  logic [4:0]  buttons;
  logic [15:0] switch;

  calculator_input_ctrl #(.DEBOUNCE_CYC(D), .HOLDOFF(H), .SW_BITS(16)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .start(start), .buttons(buttons), .switch(switch), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_starts = 0;
  int n_ovr    = 0;
  int cyc      = 0;
  int last_start = -1000;
  int min_gap    = 1000;

  // Reference model: a 2-sample delay line, a run-length debounce, and a
  // "busy cycles remaining" count standing in for the issue/holdoff sequencing.
  logic [4:0]  m_b1, m_b2, m_deb, m_deb_prev, m_code, m_pend;
  logic [15:0] m_s1, m_s2, m_sw;
  int          m_run[5];
  int          m_remain;
  logic        m_pend_v, m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input logic rst, input logic [4:0] b, input logic [15:0] s);
    logic [4:0]  ev, win, sync_old;
    logic [15:0] sw_old;
    logic        many;
    if (rst) begin
      m_b1 = '0; m_b2 = '0; m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0;
      m_code = '0; m_pend = '0; m_sw = '0; m_remain = 0; m_pend_v = 0; m_ovr = 0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      return;
    end
    ev       = m_deb & ~m_deb_prev;
    win      = ev & (~ev + 5'd1);
    many     = (ev & (ev - 5'd1)) != 0;
    sync_old = m_b2;
    sw_old   = m_s2;
    m_b2 = m_b1; m_b1 = b; m_s2 = m_s1; m_s1 = s;
    m_deb_prev = m_deb;
    for (int i = 0; i < 5; i++) begin
      if (sync_old[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_deb[i] = ~m_deb[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_ovr = 0;
    if (m_remain == 0) begin
      if (ev != 0) begin
        m_remain = H + 1; m_code = win; m_sw = sw_old; m_ovr = many;
      end
    end else if (m_remain == 1) begin
`ifdef PRESS_QUEUE_EN
      if (m_pend_v) begin
        m_remain = H + 1; m_code = m_pend; m_sw = sw_old; m_pend_v = 0; m_ovr = (ev != 0);
      end else if (ev != 0) begin
        m_remain = H + 1; m_code = win; m_sw = sw_old; m_ovr = many;
      end else begin
        m_remain = 0;
      end
`else
      m_remain = 0;
      m_ovr = (ev != 0);
`endif
    end else begin
      m_remain--;
`ifdef PRESS_QUEUE_EN
      if (ev != 0) begin
        if (m_pend_v) m_ovr = 1;
        else begin
          m_pend_v = 1; m_pend = win; m_ovr = many;
        end
      end
`else
      m_ovr = (ev != 0);
`endif
    end
  endtask

  task automatic tick(input logic rst, input logic [4:0] b, input logic [15:0] s);
    logic        e_busy;
    reset   = rst;
    btn_raw = b;
    sw_raw  = s;
    @(posedge clk);
    model_step(rst, b, s);
    #1;
    cyc++;
    e_busy = (m_remain > 0);
    check_eq("start",   32'(start),   32'(m_remain == H + 1));
    check_eq("busy",    32'(busy),    32'(e_busy));
    check_eq("buttons", 32'(buttons), 32'(e_busy ? m_code : 5'd0));
    check_eq("switch",  32'(switch),  32'(e_busy ? m_sw : m_s2));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    if (rst) begin
      last_start = -1000;
    end else if (start) begin
      n_starts++;
      if (cyc - last_start < min_gap) min_gap = cyc - last_start;
      last_start = cyc;
    end
    if (overrun) n_ovr++;
  endtask

  task automatic idle(input int n, input logic [15:0] s);
    for (int i = 0; i < n; i++) tick(1'b0, 5'd0, s);
  endtask

  int s0, o0;
  logic [4:0]  rb;
  logic [15:0] rs;

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) tick(1'b1, 5'd0, 16'hA5A5);
    check_eq("rst_start", 32'(start), 0);
    check_eq("rst_buttons", 32'(buttons), 0);
    check_eq("rst_switch", 32'(switch), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    idle(5, 16'h1234);

    // Hold LEFT with operand -10: exactly one start
    s0 = n_starts;
    for (int i = 0; i < 40; i++) tick(1'b0, 5'b00100, 16'hFFF6);
    check_eq("left_one_start", 32'(n_starts - s0), 1);
    idle(20, 16'h0003);

    // Bounce UP every cycle, then release: nothing happens
    s0 = n_starts; o0 = n_ovr;
    for (int i = 0; i < 10; i++) tick(1'b0, (i % 2 == 0) ? 5'b00001 : 5'b00000, 16'h0042);
    idle(20, 16'h0042);
    check_eq("bounce_starts", 32'(n_starts - s0), 0);
    check_eq("bounce_overrun", 32'(n_ovr - o0), 0);

    // UP and CENTER together: one start, one overrun
    s0 = n_starts; o0 = n_ovr;
    for (int i = 0; i < 30; i++) tick(1'b0, 5'b10001, 16'h0007);
    check_eq("simul_starts", 32'(n_starts - s0), 1);
    check_eq("simul_overrun", 32'(n_ovr - o0), 1);
    idle(20, 16'h0007);

    // LEFT, then DOWN three cycles later so DOWN rises during the holdoff
    s0 = n_starts;
    for (int i = 0; i < 3; i++) tick(1'b0, 5'b00100, 16'h0100);
    for (int i = 0; i < 30; i++) tick(1'b0, 5'b00110, 16'h0200 + 16'(i));
`ifdef PRESS_QUEUE_EN
    check_eq("queued_starts", 32'(n_starts - s0), 2);
`else
    check_eq("queued_starts", 32'(n_starts - s0), 1);
`endif
    idle(20, 16'h0009);

    // Reset during holdoff, then RIGHT
    s0 = n_starts;
    for (int i = 0; i < 9; i++) tick(1'b0, 5'b00100, 16'h0011);
    tick(1'b1, 5'b00000, 16'h0011);
    check_eq("abort_busy", 32'(busy), 0);
    for (int i = 0; i < 20; i++) tick(1'b0, 5'b01000, 16'h0022);
    check_eq("abort_starts", 32'(n_starts - s0), 2);
    idle(20, 16'h0022);

    // Randomized traffic
    rb = 5'd0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) rb = 5'($urandom);
      else if ($urandom_range(0, 19) == 0) rb = rb ^ 5'(1 << $urandom_range(0, 4));
      rs = 16'($urandom);
      tick(($urandom_range(0, 299) == 0), rb, rs);
    end
    idle(20, 16'h0);

    check_eq("min_start_gap_ok", 32'(min_gap >= H + 1), 1);
    check_eq("random_some_starts", 32'(n_starts > 10), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
